// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives instruction memory at PC and hands {OUT_PC, OUT_INSTRUCTION} to IF/ID.
// Outputs are combinational from state and inputs; BUSYWAIT stalls IF/ID on memory wait, STALL, DRAIN or reset.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] OUT_INSTRUCTION,
  output logic [31:0] OUT_PC,
  output logic        BUSYWAIT
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic [31:0] branch_pc;
  logic [31:0] pc_inc;

  assign branch_pc = BRANCH_TARGET & ~32'h3;
  assign pc_inc    = pc_q + 32'd4;

  always_comb begin
    IMEM_READ       = 1'b0;
    IMEM_ADDRESS    = pc_q;
    OUT_INSTRUCTION = NOP_INSTR;
    OUT_PC          = pc_q;
    BUSYWAIT        = 1'b1;
    if (RESET) begin
      IMEM_ADDRESS = RESET_PC;
      OUT_PC       = RESET_PC;
    end else begin
      case (state_q)
        FETCH: begin
          IMEM_READ       = 1'b1;
          OUT_INSTRUCTION = IMEM_READDATA;
          BUSYWAIT        = IMEM_BUSYWAIT | STALL;
        end
        HOLD: begin
          OUT_INSTRUCTION = buf_q;
          BUSYWAIT        = STALL;
        end
        DRAIN: begin
          // The abandoned access keeps its own address until memory lets go of it.
          IMEM_READ    = 1'b1;
          IMEM_ADDRESS = drain_addr_q;
        end
        default: begin
          IMEM_READ = 1'b0;
        end
      endcase
      // A redirect turns this cycle into a bubble that IF/ID captures at once.
      if (BRANCH_TAKEN) begin
        OUT_INSTRUCTION = NOP_INSTR;
        BUSYWAIT        = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    drain_addr_d = drain_addr_q;
    case (state_q)
      FETCH: begin
        if (BRANCH_TAKEN) begin
          pc_d = branch_pc;
          if (IMEM_BUSYWAIT) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (!IMEM_BUSYWAIT) begin
          if (STALL) begin
            buf_d   = IMEM_READDATA;
            state_d = HOLD;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      HOLD: begin
        if (BRANCH_TAKEN) begin
          pc_d    = branch_pc;
          state_d = FETCH;
        end else if (!STALL) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (BRANCH_TAKEN) begin
          pc_d = branch_pc;
        end
        if (!IMEM_BUSYWAIT) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      buf_q        <= NOP_INSTR;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  a_addr_stable: assert property (@(posedge CLK) disable iff (RESET)
    (IMEM_READ && IMEM_BUSYWAIT) |=> (RESET || IMEM_ADDRESS == $past(IMEM_ADDRESS)));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        stall = 1'b0;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] rdata = 32'h0;
  logic        mbusy = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .CLK(clk), .RESET(rst), .BRANCH_TAKEN(br), .BRANCH_TARGET(tgt), .STALL(stall),
    .IMEM_READ(imem_read), .IMEM_ADDRESS(imem_addr), .IMEM_READDATA(rdata),
    .IMEM_BUSYWAIT(mbusy), .OUT_INSTRUCTION(out_instr), .OUT_PC(out_pc), .BUSYWAIT(busy)
  );

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        bw;
    logic [31:0] instr;
    logic [31:0] opc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } cap_t;

  exp_t exp_q[$];
  cap_t cap_q[$];
  int total = 0;
  int bad = 0;

  // Program-flow model: where fetch points, whether a word is parked, whether a dead access is outstanding.
  logic [31:0] m_pc = RST_PC;
  bit          m_held = 1'b0;
  logic [31:0] m_word = NOP;
  bit          m_stale = 1'b0;
  logic [31:0] m_stale_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5a3c, a[31:16]} + 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit b, input logic [31:0] t, input bit s, input bit mb);
    exp_t        e;
    cap_t        c;
    logic [31:0] t_al;
    logic [31:0] data;
    @(posedge clk);
    #1;
    t_al = t & ~32'h3;
    data = $urandom;
    rst = r; br = b; tgt = t; stall = s; mbusy = mb;
    e.addr = 32'h0;
    if (r) begin
      e.rd = 1'b0; e.bw = 1'b1; e.instr = NOP; e.opc = RST_PC;
      m_pc = RST_PC; m_held = 1'b0; m_stale = 1'b0;
    end else if (m_stale) begin
      e.rd = 1'b1; e.addr = m_stale_addr; e.bw = !b; e.instr = NOP; e.opc = m_pc;
      if (b) m_pc = t_al;
      if (!mb) m_stale = 1'b0;
    end else if (m_held) begin
      e.rd = 1'b0; e.bw = b ? 1'b0 : s; e.instr = b ? NOP : m_word; e.opc = m_pc;
      if (b) begin
        m_pc = t_al; m_held = 1'b0;
      end else if (!s) begin
        m_pc = m_pc + 32'd4; m_held = 1'b0;
      end
    end else begin
      if (!mb) data = mem_word(m_pc);
      e.rd = 1'b1; e.addr = m_pc; e.bw = b ? 1'b0 : (mb | s);
      e.instr = b ? NOP : data; e.opc = m_pc;
      if (b) begin
        if (mb) begin
          m_stale = 1'b1; m_stale_addr = m_pc;
        end
        m_pc = t_al;
      end else if (!mb) begin
        if (s) begin
          m_held = 1'b1; m_word = data;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
    rdata = data;
    exp_q.push_back(e);
    if (!e.bw) begin
      c.pc = e.opc; c.instr = e.instr;
      cap_q.push_back(c);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("imem_read", {31'b0, imem_read}, {31'b0, e.rd});
        if (e.rd) chk("imem_address", imem_addr, e.addr);
        chk("busywait", {31'b0, busy}, {31'b0, e.bw});
        chk("out_instruction", out_instr, e.instr);
        chk("out_pc", out_pc, e.opc);
        if (busy === 1'b0) begin
          if (cap_q.size() == 0) begin
            total++; bad++;
            $display("FAIL capture: unexpected IF/ID capture pc=%h instr=%h", out_pc, out_instr);
          end else begin
            cap_t c;
            c = cap_q.pop_front();
            chk("capture_pc", out_pc, c.pc);
            chk("capture_instr", out_instr, c.instr);
          end
        end
      end
    end
  end

  initial begin
    // Reset, then sequential zero-wait fetches 0,4,8,C
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    // Memory wait at PC=8 for three cycles
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    // Stall while word at PC=4 returns
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    // Branch to 0x103 while PC=0x10 access waits, then drain
    step(0, 1, 32'h103, 0, 1);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
    // Branch plus stall in HOLD, then wrap from FFFFFFFC
    step(0, 0, 0, 1, 0);
    step(0, 1, 32'hFFFF_FFFC, 1, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    // Branch during DRAIN, then reset mid-drain
    step(0, 1, 32'h40, 0, 1);
    step(0, 1, 32'h80, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 1, 32'h200, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0 || cap_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queues: exp=%0d cap=%0d left, expected 0", exp_q.size(), cap_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
